// File: rtl/reorder_buffer_if.sv
// Bundle of issue, completion and commit signals around the reorder buffer.
// master: the pipeline side (issue/CDB drivers, commit consumers).
// slave:  the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int TAG_W = 4
);
    // Global stall
    logic             rdy;

    // Issue / allocation
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_wr_rd;
    logic             alloc_is_store;
    logic             alloc_is_branch;
    logic [31:0]      alloc_value;
    logic [TAG_W-1:0] alloc_tag;
    logic             rob_full;

    // Completion of simple instructions and CDB broadcasts
    logic             simple_ins_commit;
    logic [TAG_W-1:0] simple_ins_rename;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             cdb_mispredict;
    logic [31:0]      cdb_target_pc;

    // Commit side
    logic             register_update_flag;
    logic [4:0]       register_commit_dest;
    logic [31:0]      register_commit_value;
    logic [TAG_W-1:0] rename_of_commit_ins;
    logic             store_commit_valid;
    logic [TAG_W-1:0] store_commit_tag;
    logic             register_flush;
    logic [31:0]      redirect_pc;

    modport master (
        output rdy,
        output alloc_valid, alloc_rd, alloc_wr_rd, alloc_is_store, alloc_is_branch, alloc_value,
        input  alloc_tag, rob_full,
        output simple_ins_commit, simple_ins_rename,
        output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
        input  register_update_flag, register_commit_dest, register_commit_value,
        input  rename_of_commit_ins, store_commit_valid, store_commit_tag,
        input  register_flush, redirect_pc
    );

    modport slave (
        input  rdy,
        input  alloc_valid, alloc_rd, alloc_wr_rd, alloc_is_store, alloc_is_branch, alloc_value,
        output alloc_tag, rob_full,
        input  simple_ins_commit, simple_ins_rename,
        input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
        output register_update_flag, register_commit_dest, register_commit_value,
        output rename_of_commit_ins, store_commit_valid, store_commit_tag,
        output register_flush, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: hands out rename tags at issue, collects
// results from simple-instruction completion and the CDB, and retires at most
// one instruction per cycle in program order. Retirement drives the register
// file commit port, releases stores, and raises a flush with a redirect PC
// when a mispredicted branch reaches the head.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(ROB_DEPTH);

    // Entry control state (reset)
    logic [ROB_DEPTH-1:0] r_busy;
    logic [ROB_DEPTH-1:0] r_ready;

    // Entry payload (never reset; only meaningful while busy)
    logic [ROB_DEPTH-1:0] r_wr_rd;
    logic [ROB_DEPTH-1:0] r_is_store;
    logic [ROB_DEPTH-1:0] r_is_branch;
    logic [ROB_DEPTH-1:0] r_mispredict;
    logic [4:0]           r_rd     [ROB_DEPTH];
    logic [31:0]          r_value  [ROB_DEPTH];
    logic [31:0]          r_target [ROB_DEPTH];

    // Pointers and occupancy
    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_count;
    logic                 r_full;

    // Registered commit outputs
    logic                 r_upd_flag;
    logic [4:0]           r_commit_dest;
    logic [31:0]          r_commit_value;
    logic [TAG_W-1:0]     r_commit_tag;
    logic                 r_store_valid;
    logic [TAG_W-1:0]     r_store_tag;
    logic                 r_flush;
    logic [31:0]          r_redirect_pc;

    // Per-cycle decisions, all taken from registered state
    logic                 w_commit;
    logic                 w_flush;
    logic                 w_alloc_acc;
    logic                 w_cdb_hit;
    logic                 w_simple_hit;
    logic [TAG_W:0]       w_count_next;

    // The head retires once it is busy and its result was registered as ready;
    // a result arriving this cycle is only seen next cycle.
    assign w_commit     = r_busy[r_head] && r_ready[r_head];
    assign w_flush      = w_commit && r_is_branch[r_head] && r_mispredict[r_head];
    // Allocation is refused while full and discarded on a flush cycle.
    assign w_alloc_acc  = bus.alloc_valid && !r_full && !w_flush;
    // Broadcasts to entries that are not in flight are dropped.
    assign w_cdb_hit    = bus.cdb_valid && r_busy[bus.cdb_tag];
    assign w_simple_hit = bus.simple_ins_commit && r_busy[bus.simple_ins_rename];
    assign w_count_next = r_count + {{TAG_W{1'b0}}, w_alloc_acc}
                                  - {{TAG_W{1'b0}}, w_commit};

    assign bus.alloc_tag             = r_tail;
    assign bus.rob_full              = r_full;
    assign bus.register_update_flag  = r_upd_flag;
    assign bus.register_commit_dest  = r_commit_dest;
    assign bus.register_commit_value = r_commit_value;
    assign bus.rename_of_commit_ins  = r_commit_tag;
    assign bus.store_commit_valid    = r_store_valid;
    assign bus.store_commit_tag      = r_store_tag;
    assign bus.register_flush        = r_flush;
    assign bus.redirect_pc           = r_redirect_pc;

    // Entry busy/ready flags, pointers and occupancy; a flush empties the buffer.
    // NOTE: sequential state uses non-blocking assignments so every read in this
    // cycle sees the pre-edge value, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (bus.rdy) begin
            if (w_flush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                if (w_simple_hit) begin
                    r_ready[bus.simple_ins_rename] <= 1'b1;
                end
                if (w_cdb_hit) begin
                    r_ready[bus.cdb_tag] <= 1'b1;
                end
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                end
                // The tail entry is never busy when an allocation is accepted,
                // so it cannot collide with the completion updates above.
                if (w_alloc_acc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + 1'b1;
                end
                r_count <= w_count_next;
                r_full  <= (w_count_next == DEPTH_CNT);
            end
        end
    end

    // Entry payload capture at allocation and at CDB completion.
    // NOTE: the payload arrays are deliberately left out of reset; busy/ready
    // gate every use, and resetting wide storage only costs routing.
    always_ff @(posedge clk) begin
        if (bus.rdy) begin
            if (w_alloc_acc) begin
                r_rd[r_tail]         <= bus.alloc_rd;
                r_wr_rd[r_tail]      <= bus.alloc_wr_rd;
                r_is_store[r_tail]   <= bus.alloc_is_store;
                r_is_branch[r_tail]  <= bus.alloc_is_branch;
                r_value[r_tail]      <= bus.alloc_value;
                r_mispredict[r_tail] <= 1'b0;
                r_target[r_tail]     <= '0;
            end
            if (w_cdb_hit) begin
                r_value[bus.cdb_tag]      <= bus.cdb_value;
                r_mispredict[bus.cdb_tag] <= bus.cdb_mispredict;
                r_target[bus.cdb_tag]     <= bus.cdb_target_pc;
            end
        end
    end

    // Registered commit port: one-cycle pulses describing the entry retired at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_flag     <= 1'b0;
            r_commit_dest  <= '0;
            r_commit_value <= '0;
            r_commit_tag   <= '0;
            r_store_valid  <= 1'b0;
            r_store_tag    <= '0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
        end else if (bus.rdy) begin
            // A mispredicted JAL/JALR still writes its link register with the flush.
            r_upd_flag     <= w_commit && r_wr_rd[r_head] && (r_rd[r_head] != 5'd0);
            r_commit_dest  <= w_commit ? r_rd[r_head]    : 5'd0;
            r_commit_value <= w_commit ? r_value[r_head] : 32'd0;
            r_commit_tag   <= w_commit ? r_head          : '0;
            r_store_valid  <= w_commit && r_is_store[r_head];
            r_store_tag    <= (w_commit && r_is_store[r_head]) ? r_head : '0;
            r_flush        <= w_flush;
            r_redirect_pc  <= w_flush ? r_target[r_head] : 32'd0;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a table of directed vectors, hand
// sequences for full/wrap, flush, store, rd=0, stall and async reset, and a
// randomized phase, all compared against an in-order queue reference model.
module tb_reorder_buffer;
    localparam int TAG_W = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(TAG_W)) rob_if ();

    reorder_buffer #(.ROB_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rob_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          wr_rd;
        bit          is_store;
        bit          is_branch;
        logic [31:0] value;
        bit          ready;
        bit          misp;
        logic [31:0] target;
    } ent_t;

    ent_t        q[$];
    int          m_head, m_tail;
    bit          e_flag, e_st, e_flush;
    logic [4:0]  e_dest;
    logic [31:0] e_val, e_pc;
    int          e_tag;

    task automatic model_reset();
        q.delete();
        m_head = 0; m_tail = 0;
        e_flag = 0; e_st = 0; e_flush = 0;
        e_dest = '0; e_val = '0; e_pc = '0; e_tag = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit   com, fl, was_full;
        ent_t e;
        if (!rob_if.rdy) return;
        com      = (q.size() > 0) && q[0].ready;
        fl       = 0;
        was_full = (q.size() == DEPTH);
        e_flag = 0; e_st = 0; e_flush = 0;
        if (com) begin
            fl      = q[0].is_branch && q[0].misp;
            e_flag  = q[0].wr_rd && (q[0].rd != 5'd0);
            e_dest  = q[0].rd;
            e_val   = q[0].value;
            e_tag   = m_head;
            e_st    = q[0].is_store;
            e_flush = fl;
            e_pc    = q[0].target;
        end
        foreach (q[i]) begin
            if (rob_if.simple_ins_commit && q[i].tag == int'(rob_if.simple_ins_rename))
                q[i].ready = 1;
            if (rob_if.cdb_valid && q[i].tag == int'(rob_if.cdb_tag)) begin
                q[i].ready  = 1;
                q[i].value  = rob_if.cdb_value;
                q[i].misp   = rob_if.cdb_mispredict;
                q[i].target = rob_if.cdb_target_pc;
            end
        end
        if (fl) begin
            q.delete();
            m_head = 0; m_tail = 0;
            return;
        end
        if (com) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (rob_if.alloc_valid && !was_full) begin
            e.tag = m_tail; e.rd = rob_if.alloc_rd; e.wr_rd = rob_if.alloc_wr_rd;
            e.is_store = rob_if.alloc_is_store; e.is_branch = rob_if.alloc_is_branch;
            e.value = rob_if.alloc_value; e.ready = 0; e.misp = 0; e.target = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic check_model();
        check("m_flag", 32'(rob_if.register_update_flag), 32'(e_flag));
        if (e_flag) begin
            check("m_dest",  32'(rob_if.register_commit_dest), 32'(e_dest));
            check("m_value", rob_if.register_commit_value, e_val);
            check("m_tag",   32'(rob_if.rename_of_commit_ins), 32'(e_tag));
        end
        check("m_store", 32'(rob_if.store_commit_valid), 32'(e_st));
        if (e_st) check("m_store_tag", 32'(rob_if.store_commit_tag), 32'(e_tag));
        check("m_flush", 32'(rob_if.register_flush), 32'(e_flush));
        if (e_flush) check("m_redirect", rob_if.redirect_pc, e_pc);
        check("m_full", 32'(rob_if.rob_full), 32'(q.size() == DEPTH));
        check("m_alloc_tag", 32'(rob_if.alloc_tag), 32'(m_tail));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rob_if.rdy = 1; rob_if.alloc_valid = 0; rob_if.alloc_rd = '0; rob_if.alloc_wr_rd = 0;
        rob_if.alloc_is_store = 0; rob_if.alloc_is_branch = 0; rob_if.alloc_value = '0;
        rob_if.simple_ins_commit = 0; rob_if.simple_ins_rename = '0;
        rob_if.cdb_valid = 0; rob_if.cdb_tag = '0; rob_if.cdb_value = '0;
        rob_if.cdb_mispredict = 0; rob_if.cdb_target_pc = '0;
    endtask

    task automatic drive_alloc(input logic [4:0] rd, input bit wr, input bit st, input bit br,
                               input logic [31:0] val);
        rob_if.alloc_valid = 1; rob_if.alloc_rd = rd; rob_if.alloc_wr_rd = wr;
        rob_if.alloc_is_store = st; rob_if.alloc_is_branch = br; rob_if.alloc_value = val;
    endtask

    task automatic drive_cdb(input int tag, input logic [31:0] val, input bit m, input logic [31:0] tgt);
        rob_if.cdb_valid = 1; rob_if.cdb_tag = 4'(tag); rob_if.cdb_value = val;
        rob_if.cdb_mispredict = m; rob_if.cdb_target_pc = tgt;
    endtask

    // One clock: model consumes the driven inputs, DUT clocks, outputs sampled #1 later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          alloc_v;
        logic [4:0]  rd;
        bit          cdb_v;
        logic [3:0]  cdb_tag;
        logic [31:0] cdb_val;
        bit          exp_flag;
        logic [4:0]  exp_dest;
        logic [31:0] exp_val;
        logic [3:0]  exp_tag;
        logic [3:0]  exp_atag;
    } vec_t;

    vec_t vecs[9];
    bit   seen;
    bit   br, st;
    int   k, k2;

    initial begin
        // Three ALU ops, results arrive out of order, retire in order.
        vecs[0] = '{1, 5, 0, 0, 0,     0, 0, 0,     0, 1};
        vecs[1] = '{1, 6, 0, 0, 0,     0, 0, 0,     0, 2};
        vecs[2] = '{1, 7, 0, 0, 0,     0, 0, 0,     0, 3};
        vecs[3] = '{0, 0, 1, 2, 'h11,  0, 0, 0,     0, 3};
        vecs[4] = '{0, 0, 1, 0, 'h22,  0, 0, 0,     0, 3};
        vecs[5] = '{0, 0, 1, 1, 'h33,  1, 5, 'h22,  0, 3};
        vecs[6] = '{0, 0, 0, 0, 0,     1, 6, 'h33,  1, 3};
        vecs[7] = '{0, 0, 0, 0, 0,     1, 7, 'h11,  2, 3};
        vecs[8] = '{0, 0, 0, 0, 0,     0, 0, 0,     0, 3};

        model_reset();
        do_reset();
        check("reset_flag",  32'(rob_if.register_update_flag), 32'd0);
        check("reset_store", 32'(rob_if.store_commit_valid), 32'd0);
        check("reset_flush", 32'(rob_if.register_flush), 32'd0);
        check("reset_full",  32'(rob_if.rob_full), 32'd0);
        check("reset_tag",   32'(rob_if.alloc_tag), 32'd0);

        for (int i = 0; i < 9; i++) begin
            idle();
            if (vecs[i].alloc_v) drive_alloc(vecs[i].rd, 1, 0, 0, 32'd0);
            if (vecs[i].cdb_v)   drive_cdb(int'(vecs[i].cdb_tag), vecs[i].cdb_val, 0, 32'd0);
            tick();
            check($sformatf("vec%0d_flag", i), 32'(rob_if.register_update_flag), 32'(vecs[i].exp_flag));
            if (vecs[i].exp_flag) begin
                check($sformatf("vec%0d_dest", i), 32'(rob_if.register_commit_dest), 32'(vecs[i].exp_dest));
                check($sformatf("vec%0d_value", i), rob_if.register_commit_value, vecs[i].exp_val);
                check($sformatf("vec%0d_tag", i), 32'(rob_if.rename_of_commit_ins), 32'(vecs[i].exp_tag));
            end
            check($sformatf("vec%0d_atag", i), 32'(rob_if.alloc_tag), 32'(vecs[i].exp_atag));
        end

        // Fill to 16, 17th ignored, retire head, wrap to tag 0.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle(); drive_alloc(5'(i + 1), 1, 0, 0, 32'(i)); tick();
        end
        check("full_set", 32'(rob_if.rob_full), 32'd1);
        check("full_tail", 32'(rob_if.alloc_tag), 32'd0);
        idle(); drive_alloc(5'd20, 1, 0, 0, 32'd5); tick();
        check("full_17th_ignored", 32'(rob_if.alloc_tag), 32'd0);
        idle(); drive_cdb(0, 32'hAA, 0, 32'd0); tick();
        check("full_still", 32'(rob_if.rob_full), 32'd1);
        idle(); tick();
        check("full_commit_flag", 32'(rob_if.register_update_flag), 32'd1);
        check("full_commit_value", rob_if.register_commit_value, 32'hAA);
        check("full_dropped", 32'(rob_if.rob_full), 32'd0);
        check("wrap_next_tag", 32'(rob_if.alloc_tag), 32'd0);
        idle(); drive_alloc(5'd21, 1, 0, 0, 32'd0); tick();
        check("wrap_tail", 32'(rob_if.alloc_tag), 32'd1);
        check("wrap_full", 32'(rob_if.rob_full), 32'd1);

        // Mispredicted branch at tag 3 with younger tags 4..6 in flight.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 3) drive_alloc(5'd0, 0, 0, 1, 32'd0);
            else        drive_alloc(5'(i + 1), 1, 0, 0, 32'd0);
            tick();
        end
        idle(); drive_cdb(3, 32'h3, 1, 32'h1000); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); drive_cdb(i, 32'(i + 100), 0, 32'd0); tick();
        end
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            idle();
            // Allocation offered on the flush cycle must be discarded.
            if (q.size() > 0 && q[0].ready && q[0].is_branch && q[0].misp)
                drive_alloc(5'd9, 1, 0, 0, 32'h9);
            tick();
            if (rob_if.register_flush) seen = 1;
        end
        check("flush_seen", 32'(seen), 32'd1);
        check("flush_redirect", rob_if.redirect_pc, 32'h1000);
        check("flush_no_rd_write", 32'(rob_if.register_update_flag), 32'd0);
        idle(); tick();
        check("flush_one_cycle", 32'(rob_if.register_flush), 32'd0);
        check("flush_tail_zero", 32'(rob_if.alloc_tag), 32'd0);
        check("flush_not_full", 32'(rob_if.rob_full), 32'd0);
        idle(); drive_cdb(5, 32'h5555, 0, 32'd0); tick();
        idle(); tick();
        check("flush_stale_cdb_flag", 32'(rob_if.register_update_flag), 32'd0);
        check("flush_stale_cdb_tag", 32'(rob_if.alloc_tag), 32'd0);

        // Store released at head.
        do_reset();
        idle(); drive_alloc(5'd0, 0, 1, 0, 32'd0); tick();
        idle(); drive_cdb(0, 32'h1234, 0, 32'd0); tick();
        check("store_not_yet", 32'(rob_if.store_commit_valid), 32'd0);
        idle(); tick();
        check("store_valid", 32'(rob_if.store_commit_valid), 32'd1);
        check("store_tag", 32'(rob_if.store_commit_tag), 32'd0);
        check("store_no_rd", 32'(rob_if.register_update_flag), 32'd0);
        idle(); tick();
        check("store_pulse_end", 32'(rob_if.store_commit_valid), 32'd0);

        // rd=0 retires silently; simple_ins_commit uses the allocation value.
        idle(); drive_alloc(5'd0, 1, 0, 0, 32'h5); tick();
        idle(); drive_alloc(5'd10, 1, 0, 0, 32'hABCD0000); tick();
        idle(); drive_cdb(1, 32'h55, 0, 32'd0);
        rob_if.simple_ins_commit = 1; rob_if.simple_ins_rename = 4'd2; tick();
        idle(); tick();
        check("rd0_no_write", 32'(rob_if.register_update_flag), 32'd0);
        idle(); tick();
        check("simple_flag", 32'(rob_if.register_update_flag), 32'd1);
        check("simple_dest", 32'(rob_if.register_commit_dest), 32'd10);
        check("simple_value", rob_if.register_commit_value, 32'hABCD0000);
        check("simple_tag", 32'(rob_if.rename_of_commit_ins), 32'd2);

        // rdy=0 freezes everything for 5 cycles despite CDB and issue activity.
        do_reset();
        idle(); drive_alloc(5'd3, 1, 0, 0, 32'd0); tick();
        idle(); drive_alloc(5'd4, 1, 0, 0, 32'd0); tick();
        idle(); drive_cdb(0, 32'h77, 0, 32'd0); tick();
        idle(); drive_cdb(1, 32'h88, 0, 32'd0); tick();
        for (int i = 0; i < 5; i++) begin
            idle(); rob_if.rdy = 0;
            drive_alloc(5'd7, 1, 0, 0, 32'd1); drive_cdb(1, 32'h99, 0, 32'd0);
            tick();
            check("hold_flag", 32'(rob_if.register_update_flag), 32'd1);
            check("hold_value", rob_if.register_commit_value, 32'h77);
            check("hold_tail", 32'(rob_if.alloc_tag), 32'd2);
        end
        idle(); tick();
        check("after_hold_value", rob_if.register_commit_value, 32'h88);
        check("after_hold_tag", 32'(rob_if.rename_of_commit_ins), 32'd1);
        check("after_hold_tail", 32'(rob_if.alloc_tag), 32'd2);

        // Asynchronous reset in the middle of a commit pulse.
        idle(); drive_alloc(5'd5, 1, 0, 0, 32'd0); tick();
        idle(); drive_cdb(2, 32'h66, 0, 32'd0); tick();
        idle(); tick();
        check("pre_rst_flag", 32'(rob_if.register_update_flag), 32'd1);
        #2 rst = 1;
        #1;
        check("arst_flag",  32'(rob_if.register_update_flag), 32'd0);
        check("arst_dest",  32'(rob_if.register_commit_dest), 32'd0);
        check("arst_value", rob_if.register_commit_value, 32'd0);
        check("arst_tag",   32'(rob_if.rename_of_commit_ins), 32'd0);
        check("arst_store", 32'(rob_if.store_commit_valid), 32'd0);
        check("arst_flush", 32'(rob_if.register_flush), 32'd0);
        check("arst_pc",    rob_if.redirect_pc, 32'd0);
        check("arst_full",  32'(rob_if.rob_full), 32'd0);
        check("arst_atag",  32'(rob_if.alloc_tag), 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();

        // Randomized traffic against the queue model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            rob_if.rdy = ($urandom_range(9) != 0);
            if ($urandom_range(9) < 6) begin
                br = ($urandom_range(6) == 0);
                st = !br && ($urandom_range(4) == 0);
                drive_alloc(5'($urandom), !st && ($urandom_range(3) != 0), st, br, $urandom);
            end
            if (q.size() > 0 && $urandom_range(9) < 6) begin
                k = int'($urandom_range(q.size() - 1));
                drive_cdb(q[k].tag, $urandom, q[k].is_branch && ($urandom_range(3) == 0), $urandom);
            end else if ($urandom_range(9) == 0) begin
                drive_cdb(int'($urandom_range(15)), $urandom, $urandom_range(1) == 1, $urandom);
            end
            if (q.size() > 0 && $urandom_range(4) == 0) begin
                k2 = int'($urandom_range(q.size() - 1));
                if (!(rob_if.cdb_valid && int'(rob_if.cdb_tag) == q[k2].tag)) begin
                    rob_if.simple_ins_commit = 1;
                    rob_if.simple_ins_rename = 4'(q[k2].tag);
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
